warp_issue_arbiter: RTL
=======================

// Module: warp_issue_arbiter
// PURPOSE
// Resident-warp table and issue arbiter between warp_scheduler and the SIMD cores.
// Accepts warps (starting PC, thread count) from the scheduler and holds up to NUM_WARPS of them.
// Round-robins ready warps onto free SIMD cores over a valid/ack handshake.
// Retires warps on core completion and reports the finished warp id back to the scheduler.
// PARAMETERS
// NUM_WARPS       16  warp table slots; warp id = slot index (WARP_W = 4 bits)
// NUM_SIMD_CORES  4   issue targets (CORE_W = $clog2(NUM_SIMD_CORES))
// THREAD_W        LOG2_THREAD_COUNT  width of the thread-count field
// PORTS
// clk                  in   1         single clock, all logic on posedge
// rst                  in   1         synchronous, active-high reset
// alloc_valid          in   1         scheduler presents a new warp
// alloc_ready          out  1         at least one FREE slot exists (from registered state only)
// alloc_pc             in   32        warp starting PC
// alloc_threads        in   THREAD_W  active thread count of the warp
// issue_valid          out  1         registered; warp offered to issue_core
// issue_core           out  CORE_W    target SIMD core
// issue_warp_id        out  WARP_W    offered slot index
// issue_pc             out  32        offered starting PC
// issue_threads        out  THREAD_W  offered thread count
// issue_ack            in   1         target core accepted the offer
// core_done            in   1         a core finished its warp
// core_done_id         in   CORE_W    which core finished
// finished_valid       out  1         one-cycle pulse: warp retired
// finished_warp_id     out  WARP_W    id of the retired warp
// resident_count       out  WARP_W+1  number of non-FREE slots
// BEHAVIOUR
// - Reset: slots FREE, cores free, rr_ptr=0, FSM IDLE.
//   All outputs 0 except alloc_ready=1. Reset during OFFER drops the offer.
// - Slot states: FREE -> READY (alloc) -> PENDING (offered) -> RUNNING (acked) -> FREE (done).
// - Alloc: on alloc_valid && alloc_ready, the lowest-index FREE slot becomes READY next cycle
//   and latches PC and thread count.
//   alloc_threads==0: the handshake completes, no slot is consumed and finished_valid does not pulse.
// - Issue FSM IDLE:
//   Candidate slot = first READY slot scanning from rr_ptr upward, wrapping at NUM_WARPS-1.
//   Target core = lowest-index free core.
//   If both exist: load issue_* regs, set issue_valid=1, slot -> PENDING, go to OFFER.
//   Otherwise issue_valid=0.
// - Issue FSM OFFER:
//   issue_* stays stable while issue_ack=0.
//   On issue_ack: slot -> RUNNING, core marked busy with that warp id,
//   rr_ptr = (warp_id+1) mod NUM_WARPS, issue_valid=0, go to IDLE.
//   Peak throughput is one issue per 2 cycles.
// - Latency: a slot that becomes READY while in IDLE with a free core
//   gives issue_valid=1 on the following cycle.
// - Completion: core_done on a busy core frees the core and its slot;
//   finished_valid=1 and finished_warp_id are registered, one cycle after core_done.
//   core_done on an idle core is ignored (no pulse).
// - Simultaneous events use registered state only:
//   - A slot freed by core_done is not allocatable in the same cycle.
//   - A core freed by core_done is not issuable in the same cycle.
//   - issue_ack and core_done on the same core in one cycle: the ack is applied and the done is ignored.
// - resident_count: registered; updated on alloc (+1) and retire (-1).
//   Both in one cycle leave it unchanged. Range 0..NUM_WARPS, never wraps.
// - Full: resident_count==NUM_WARPS forces alloc_ready=0; alloc_valid is held off and nothing is lost.
// TESTING
// - Reset, then alloc PC=0x1234_5678, threads=4:
//   slot 0 READY; issue_valid=1 two cycles after the alloc cycle, issue_core=0, issue_warp_id=0, issue_threads=4.
// - Alloc three warps (PC 0x1234_5678/4, 0x8765_4321/2, 0xABCD_EF01/7), ack each offer immediately:
//   issue order is warp 0,1,2 onto cores 0,1,2; resident_count=3.
// - Hold issue_ack=0 for 5 cycles during an OFFER:
//   issue_* is stable throughout; on ack the slot is RUNNING and the next offer follows 2 cycles later.
// - Fill all 16 slots with 4 cores busy: alloc_ready=0.
//   core_done with core_done_id=2 gives finished_valid one cycle later with that core's warp id,
//   then alloc_ready=1 and a waiting warp issues to core 2.
// - Round-robin wrap: rr_ptr=15 with slots 15 and 0 READY, then 15 is issued and 0 follows.
//   Separately: core_done on an idle core gives no finished_valid;
//   assert rst mid-OFFER, then all outputs read 0 and alloc_ready=1 the next cycle.

Source files
------------

// File: rtl/warp_issue_arbiter.sv
// Resident-warp table plus round-robin issue arbiter: holds scheduler warps in slots,
// offers READY warps to free SIMD cores over valid/ack and retires them on core completion.

module warp_slot #(
   parameter int THREAD_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                alloc,
   input  logic                offer,
   input  logic                ack,
   input  logic                retire,
   input  logic [31:0]         alloc_pc,
   input  logic [THREAD_W-1:0] alloc_threads,
   output logic                free,
   output logic                ready,
   output logic [31:0]         pc,
   output logic [THREAD_W-1:0] threads
);
   typedef enum logic [1:0] {FREE, READY, PENDING, RUNNING} slot_e;
   slot_e state;

   // The parent only raises each strobe when the slot is in the matching source state.
   always_ff @(posedge clk) begin
      if (rst)         state <= FREE;
      else if (alloc)  state <= READY;
      else if (offer)  state <= PENDING;
      else if (ack)    state <= RUNNING;
      else if (retire) state <= FREE;
   end

   always_ff @(posedge clk) begin
      if (alloc) begin
         pc      <= alloc_pc;
         threads <= alloc_threads;
      end
   end

   assign free  = (state == FREE);
   assign ready = (state == READY);
endmodule

module warp_issue_arbiter #(
   parameter  int NUM_WARPS      = 16,
   parameter  int NUM_SIMD_CORES = 4,
   parameter  int THREAD_W       = 4,
   localparam int WARP_W         = $clog2(NUM_WARPS),
   localparam int CORE_W         = $clog2(NUM_SIMD_CORES)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                alloc_valid,
   output logic                alloc_ready,
   input  logic [31:0]         alloc_pc,
   input  logic [THREAD_W-1:0] alloc_threads,
   output logic                issue_valid,
   output logic [CORE_W-1:0]   issue_core,
   output logic [WARP_W-1:0]   issue_warp_id,
   output logic [31:0]         issue_pc,
   output logic [THREAD_W-1:0] issue_threads,
   input  logic                issue_ack,
   input  logic                core_done,
   input  logic [CORE_W-1:0]   core_done_id,
   output logic                finished_valid,
   output logic [WARP_W-1:0]   finished_warp_id,
   output logic [WARP_W:0]     resident_count
);
   typedef enum logic {IDLE, OFFER} fsm_e;
   fsm_e state, state_nxt;

   logic [NUM_WARPS-1:0]                slot_free, slot_ready;
   logic [NUM_WARPS-1:0]                slot_alloc, slot_offer, slot_ack, slot_retire;
   logic [NUM_WARPS-1:0][31:0]          slot_pc;
   logic [NUM_WARPS-1:0][THREAD_W-1:0]  slot_threads;
   logic [NUM_SIMD_CORES-1:0]           core_busy;
   logic [NUM_SIMD_CORES-1:0][WARP_W-1:0] core_warp;
   logic [WARP_W-1:0]                   rr_ptr;

   logic              alloc_fire, start, ack_fire, done_fire;
   logic [WARP_W-1:0] alloc_idx, cand_idx;
   logic              cand_found, core_found;
   logic [CORE_W-1:0] core_idx;

   for (genvar g = 0; g < NUM_WARPS; g++) begin : g_slot
      warp_slot #(.THREAD_W(THREAD_W)) u_slot (
         .clk           (clk),
         .rst           (rst),
         .alloc         (slot_alloc[g]),
         .offer         (slot_offer[g]),
         .ack           (slot_ack[g]),
         .retire        (slot_retire[g]),
         .alloc_pc      (alloc_pc),
         .alloc_threads (alloc_threads),
         .free          (slot_free[g]),
         .ready         (slot_ready[g]),
         .pc            (slot_pc[g]),
         .threads       (slot_threads[g])
      );
   end

   assign alloc_ready = (resident_count != (WARP_W+1)'(NUM_WARPS));
   // Zero-thread warps complete the handshake without occupying a slot.
   assign alloc_fire  = alloc_valid && alloc_ready && (alloc_threads != '0);

   always_comb begin
      alloc_idx = '0;
      for (int i = NUM_WARPS-1; i >= 0; i--)
         if (slot_free[i]) alloc_idx = WARP_W'(i);
   end

   // Reverse scan so the slot closest to rr_ptr (in wrap order) wins.
   always_comb begin
      logic [WARP_W:0] s;
      cand_found = 1'b0;
      cand_idx   = '0;
      s          = '0;
      for (int i = NUM_WARPS-1; i >= 0; i--) begin
         s = {1'b0, rr_ptr} + (WARP_W+1)'(i);
         if (s >= (WARP_W+1)'(NUM_WARPS)) s = s - (WARP_W+1)'(NUM_WARPS);
         if (slot_ready[s[WARP_W-1:0]]) begin
            cand_found = 1'b1;
            cand_idx   = s[WARP_W-1:0];
         end
      end
   end

   always_comb begin
      core_found = 1'b0;
      core_idx   = '0;
      for (int c = NUM_SIMD_CORES-1; c >= 0; c--)
         if (!core_busy[c]) begin
            core_found = 1'b1;
            core_idx   = CORE_W'(c);
         end
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      ack_fire  = 1'b0;
      case (state)
         IDLE:  if (cand_found && core_found) begin
                   start     = 1'b1;
                   state_nxt = OFFER;
                end
         OFFER: if (issue_ack) begin
                   ack_fire  = 1'b1;
                   state_nxt = IDLE;
                end
         default: state_nxt = IDLE;
      endcase
   end

   // An ack to a core wins over a done on that same core.
   assign done_fire = core_done && core_busy[core_done_id] &&
                      !(ack_fire && (issue_core == core_done_id));

   always_comb begin
      slot_alloc  = '0;
      slot_offer  = '0;
      slot_ack    = '0;
      slot_retire = '0;
      if (alloc_fire) slot_alloc[alloc_idx]                = 1'b1;
      if (start)      slot_offer[cand_idx]                 = 1'b1;
      if (ack_fire)   slot_ack[issue_warp_id]              = 1'b1;
      if (done_fire)  slot_retire[core_warp[core_done_id]] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         issue_valid      <= 1'b0;
         issue_core       <= '0;
         issue_warp_id    <= '0;
         issue_pc         <= '0;
         issue_threads    <= '0;
         rr_ptr           <= '0;
         core_busy        <= '0;
         core_warp        <= '0;
         finished_valid   <= 1'b0;
         finished_warp_id <= '0;
         resident_count   <= '0;
      end else begin
         state          <= state_nxt;
         finished_valid <= done_fire;
         if (done_fire) begin
            finished_warp_id        <= core_warp[core_done_id];
            core_busy[core_done_id] <= 1'b0;
         end
         if (start) begin
            issue_valid   <= 1'b1;
            issue_core    <= core_idx;
            issue_warp_id <= cand_idx;
            issue_pc      <= slot_pc[cand_idx];
            issue_threads <= slot_threads[cand_idx];
         end
         if (ack_fire) begin
            issue_valid           <= 1'b0;
            core_busy[issue_core] <= 1'b1;
            core_warp[issue_core] <= issue_warp_id;
            rr_ptr <= (issue_warp_id == WARP_W'(NUM_WARPS-1)) ? '0 : issue_warp_id + WARP_W'(1);
         end
         if (alloc_fire && !done_fire)      resident_count <= resident_count + 1'b1;
         else if (!alloc_fire && done_fire) resident_count <= resident_count - 1'b1;
      end
   end
endmodule
